// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single memory with read timeout and error reporting
module mem_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3,
  parameter int TIMEOUT    = 7
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  req0,
  input  logic                  wr0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  done0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic                  err0,
  output logic                  gnt1,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  err1,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_valid_out,
  input  logic                  mem_err,
  output logic                  busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                r_state, w_next;
  logic                  r_win, r_wr, r_prio, r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata0, r_rdata1;
  logic [CW-1:0]         r_cnt;
  logic                  w_any, w_win, w_issue, w_wait, w_done, w_timeout;

  assign w_any     = req0 | req1;
  assign w_win     = (req0 & req1) ? r_prio : req1;
  assign w_issue   = r_state == S_ISSUE;
  assign w_wait    = r_state == S_WAIT;
  assign w_done    = r_state == S_DONE;
  assign w_timeout = w_wait & ~mem_valid_out & (r_cnt == CNT_LAST);

  assign busy        = r_state != S_IDLE;
  assign gnt0        = w_issue & ~r_win;
  assign gnt1        = w_issue & r_win;
  assign done0       = w_done & ~r_win;
  assign done1       = w_done & r_win;
  assign err0        = done0 & r_err;
  assign err1        = done1 & r_err;
  assign mem_write   = w_issue & r_wr;
  assign mem_read    = w_issue & ~r_wr;
  assign mem_address = (w_issue | w_wait) ? r_addr : '0;
  assign mem_data    = w_issue ? r_wdata : '0;
  assign rdata0      = r_rdata0;
  assign rdata1      = r_rdata1;

  // state register
  always_ff @(posedge clk) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next-state: reads wait for data or timeout, writes complete straight after issue
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_any ? S_ISSUE : S_IDLE;
      S_ISSUE: w_next = r_wr ? S_DONE : S_WAIT;
      S_WAIT:  w_next = (mem_valid_out | w_timeout) ? S_DONE : S_WAIT;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // latch the winning request and track error, timeout count and round-robin pointer
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_win   <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_prio  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_win   <= w_win;
        r_wr    <= w_win ? wr1 : wr0;
        r_addr  <= w_win ? addr1 : addr0;
        r_wdata <= w_win ? wdata1 : wdata0;
        r_err   <= 1'b0;
      end
      if (((w_issue | w_wait) & mem_err) | w_timeout) r_err <= 1'b1;
      r_cnt <= w_wait ? r_cnt + 1'b1 : '0;
      if (w_next == S_DONE) r_prio <= ~r_win;
    end
  end

  // per-port read data, updated only by a returned read
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (w_wait && mem_valid_out) begin
      if (r_win) r_rdata1 <= mem_data_out;
      else       r_rdata0 <= mem_data_out;
    end
  end
endmodule
